// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, writeback, issue/scoreboard and debug access.
// The master (decode/writeback/debug side) drives addresses and strobes; the slave is the register file.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;
  logic                pend_any;
  logic                sb_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush, dbg_addr,
    input  rd_data, rd_busy, dbg_data, pend_any, sb_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush, dbg_addr,
    output rd_data, rd_busy, dbg_data, pend_any, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass and a per-register pending-write scoreboard.
// x0 is hard-wired zero; the scoreboard counts issued-but-not-written-back destinations.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2,
  parameter int PW   = 2
) (
  input logic          clk,
  input logic          rst,
  regfile_sb_if.slave  bus
);

  localparam logic [PW-1:0] CNT_MAX  = {PW{1'b1}};
  localparam logic [PW-1:0] CNT_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] CNT_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_X0  = {AW{1'b0}};

  logic [XLEN-1:0]     mem_r     [NREG];
  logic [PW-1:0]       cnt_r     [NREG];
  logic [PW-1:0]       cnt_nxt_s [NREG];
  logic                iss_hit_s [NREG];
  logic                wr_hit_s  [NREG];
  logic                err_s;
  logic                sb_err_r;
  logic                pend_s;
  logic [AW-1:0]       ra_s      [NRD];
  logic [NRD*XLEN-1:0] rd_data_s;
  logic [NRD-1:0]      rd_busy_s;

  // Decode which register the issue and writeback strobes address this cycle
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      if (r == 0) begin
        iss_hit_s[r] = 1'b0;
        wr_hit_s[r]  = 1'b0;
      end else begin
        iss_hit_s[r] = bus.iss_en && (bus.iss_addr == AW'(r));
        wr_hit_s[r]  = bus.wr_en && (bus.wr_addr == AW'(r));
      end
    end
  end

  // Next pending count per register; saturating at both ends flags a scoreboard error
  always_comb begin
    err_s = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt_s[r] = cnt_r[r];
      if ((r == 0) || bus.flush) begin
        cnt_nxt_s[r] = CNT_ZERO;
      end else begin
        case ({iss_hit_s[r], wr_hit_s[r]})
          2'b10: begin
            if (cnt_r[r] == CNT_MAX) begin
              err_s = 1'b1;
            end else begin
              cnt_nxt_s[r] = cnt_r[r] + CNT_ONE;
            end
          end
          2'b01: begin
            if (cnt_r[r] == CNT_ZERO) begin
              err_s = 1'b1;
            end else begin
              cnt_nxt_s[r] = cnt_r[r] - CNT_ONE;
            end
          end
          default: cnt_nxt_s[r] = cnt_r[r];
        endcase
      end
    end
  end

  // Register array; x0 is never written so it stays zero from reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        mem_r[r] <= {XLEN{1'b0}};
      end
    end else if (bus.wr_en && (bus.wr_addr != ADDR_X0)) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end else begin
      mem_r[0] <= {XLEN{1'b0}};
    end
  end

  // Pending-write counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
    end
  end

  // Sticky error flag; a flush cycle suppresses counter effects and hence errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_err_r <= 1'b0;
    end else if (err_s) begin
      sb_err_r <= 1'b1;
    end else begin
      sb_err_r <= sb_err_r;
    end
  end

  // Read ports with writeback bypass; the last in-flight write arriving now clears busy
  always_comb begin
    rd_data_s = {(NRD*XLEN){1'b0}};
    rd_busy_s = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      ra_s[k] = bus.rd_addr[k*AW +: AW];
      if (!rst || (ra_s[k] == ADDR_X0)) begin
        rd_data_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy_s[k]              = 1'b0;
      end else if (bus.wr_en && (bus.wr_addr == ra_s[k])) begin
        rd_data_s[k*XLEN +: XLEN] = bus.wr_data;
        rd_busy_s[k]              = (cnt_r[ra_s[k]] != CNT_ZERO) && (cnt_r[ra_s[k]] != CNT_ONE);
      end else begin
        rd_data_s[k*XLEN +: XLEN] = mem_r[ra_s[k]];
        rd_busy_s[k]              = (cnt_r[ra_s[k]] != CNT_ZERO);
      end
    end
  end

  // Any register with an outstanding write
  always_comb begin
    pend_s = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (cnt_r[r] != CNT_ZERO) begin
        pend_s = 1'b1;
      end else begin
        pend_s = pend_s;
      end
    end
  end

  assign bus.rd_data  = rd_data_s;
  assign bus.rd_busy  = rd_busy_s;
  assign bus.dbg_data = mem_r[bus.dbg_addr];
  assign bus.pend_any = pend_s;
  assign bus.sb_err   = sb_err_r;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated pending-write scoreboard. It serves the decode stage with NRD combinational read ports and internal write-to-read bypass, and accepts one writeback per cycle. Decode marks each issued destination as pending; the block tracks in-flight writes per register so decode can detect RAW hazards without external comparators. A debug read port replaces hard-wired register taps.

## Interface
- XLEN, 32: data width of each register.
- NREG, 32: number of architectural registers (power of 2, ≥2).
- AW, $clog2(NREG): register address width.
- NRD, 2: number of read ports.
- PW, 2: per-register pending-counter width; maximum in-flight writes per register is 2^PW−1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational, port k at [k*XLEN +: XLEN].
- rd_busy  out  NRD  port k's register has ≥1 pending write not yet written back.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  decode issued an instruction that will write iss_addr.
- iss_addr  in  AW  issued destination.
- flush  in  1  synchronous scoreboard clear (pipeline flush).
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data, raw array contents, no bypass.
- pend_any  out  1  OR of all pending counters being non-zero.
- sb_err  out  1  sticky scoreboard error (overflow or underflow).

## Operation
- Register 0 is hard-wired zero: reads return 0, rd_busy for it is 0, writes and issues to address 0 are ignored (no counter change, no error).
- Write: on rising edge with wr_en=1 and wr_addr≠0, array[wr_addr] ← wr_data.
- Read port k: if wr_en=1, wr_addr=rd_addr[k] and rd_addr[k]≠0 → rd_data = wr_data (bypass); else array[rd_addr[k]]. Bypass makes a same-cycle writeback visible to decode.
- rd_busy[k] = (cnt[rd_addr[k]] ≠ 0) and not (wr_en and wr_addr=rd_addr[k] and cnt=1): the last pending write, arriving this cycle, is covered by the bypass.
- Pending counter cnt[r] (PW bits) per register r≠0, updated each rising edge:
  - iss only for r: cnt+1; if cnt already at max → cnt holds, sb_err set.
  - wr only for r: cnt−1; if cnt already 0 → cnt holds, sb_err set; data write still occurs.
  - iss and wr to same r in same cycle: cnt unchanged, no error, even at 0 or max.
  - iss and wr to different registers: each updated independently.
- flush=1: all counters ← 0 at the edge; overrides same-cycle iss/wr counter effects; the data write still occurs; sb_err unchanged.
- sb_err is sticky; cleared only by reset.
- No state machine beyond counters; the array holds state until overwritten or reset.

## Timing
- Reset (rst=0, asynchronous, any time): array all 0, all cnt 0, sb_err 0. Outputs while in reset: rd_data 0, dbg_data 0, rd_busy 0, pend_any 0, sb_err 0. Reset asserted mid-operation discards pending writes. First update occurs on the first rising edge after rst deasserts.
- Read latency 0 (combinational from rd_addr, wr_*).
- Write latency 1: data visible via the array (and dbg_data) the cycle after the wr_en edge; visible same cycle via rd_data bypass.
- Issue: rd_busy for that register rises the cycle after iss_en.
- pend_any and sb_err are registered state decoded combinationally and change only after rising edges or at reset.

## Test plan
- Reset then read: rst=0 mid-run with x5=0x1234 → rd_data 0, dbg_data(5)=0, rd_busy 0, sb_err 0 immediately, without a clock edge.
- Bypass: wr_en=1, wr_addr=7, wr_data=0xDEADBEEF, rd_addr[0]=7 same cycle → rd_data[0]=0xDEADBEEF; dbg_data(7) shows the old value until the edge.
- x0: write 0xFFFFFFFF to addr 0 plus iss to 0 → rd_data 0, rd_busy 0, sb_err 0.
- Scoreboard: iss x3 on 3 consecutive cycles → cnt=3, rd_busy=1; a 4th iss → sb_err=1, cnt stays 3; 3 writebacks → rd_busy drops in the cycle of the 3rd writeback (bypass); pend_any=0 afterwards.
- Simultaneous iss+wr to x9 at cnt=0 → cnt stays 0, no error; wr to x9 alone at cnt=0 → sb_err=1, array updated.
- Flush: cnt[4]=2, cnt[6]=1, flush with same-cycle iss x8 → all cnt 0, pend_any=0, x8 not busy, register data retained.
